// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for the multi-cycle divider.
// Accepts div/divu requests from EX, drives the divider start/annul/operand
// interface, stalls the pipeline until the result returns and presents a
// one-cycle HI/LO writeback. Flushes mid-divide annul the divider and open a
// drain window before a new divide may start.
// Optional build macro DIV_CACHE_EN adds a one-entry result cache that
// answers an exact repeat of the last completed divide in the request cycle.
module div_ctrl #(
    parameter int DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        div_signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        flush_i,
    input  logic        ex_stall_i,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        signed_div_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_zero_o
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, DRAIN} state_t;

    state_t            state;
    logic              sgn_q;
    logic [31:0]       op1_q;
    logic [31:0]       op2_q;
    logic [CNT_W-1:0]  cnt_q;

    // Request that is allowed to act this cycle (EX holds a divide, not flushed)
    logic              req_ok;
    // A completed divide leaves RUN this cycle
    logic              run_done;
    logic              cache_hit;
    logic [31:0]       hit_hi;
    logic [31:0]       hit_lo;
    logic              hit_zero;

    assign req_ok   = div_req_i & ~flush_i;
    assign run_done = (state == RUN) & div_ready_i & ~flush_i;

`ifdef DIV_CACHE_EN
    logic        c_vld;
    logic        c_sgn;
    logic [31:0] c_op1;
    logic [31:0] c_op2;
    logic [31:0] c_hi;
    logic [31:0] c_lo;
    logic        c_zero;

    // Capture every normal completion; an annulled divide never reaches here
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_vld  <= 1'b0;
            c_sgn  <= 1'b0;
            c_op1  <= '0;
            c_op2  <= '0;
            c_hi   <= '0;
            c_lo   <= '0;
            c_zero <= 1'b0;
        end else if (run_done) begin
            c_vld  <= 1'b1;
            c_sgn  <= sgn_q;
            c_op1  <= op1_q;
            c_op2  <= op2_q;
            c_hi   <= div_result_i[63:32];
            c_lo   <= div_result_i[31:0];
            c_zero <= (op2_q == '0);
        end
    end

    assign cache_hit = c_vld & (c_sgn == div_signed_i) &
                       (c_op1 == opdata1_i) & (c_op2 == opdata2_i);
    assign hit_hi    = c_hi;
    assign hit_lo    = c_lo;
    assign hit_zero  = c_zero;
`else
    assign cache_hit = 1'b0;
    assign hit_hi    = '0;
    assign hit_lo    = '0;
    assign hit_zero  = 1'b0;
`endif

    // Sequencer state, operand latches and drain counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sgn_q <= 1'b0;
            op1_q <= '0;
            op2_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        if (cache_hit) begin
                            state <= ex_stall_i ? DONE : IDLE;
                        end else begin
                            state <= RUN;
                            sgn_q <= div_signed_i;
                            op1_q <= opdata1_i;
                            op2_q <= opdata2_i;
                        end
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        state <= DRAIN;
                        cnt_q <= DRAIN_INIT;
                    end else if (div_ready_i) begin
                        state <= ex_stall_i ? DONE : IDLE;
                    end
                end
                DONE: begin
                    if (!ex_stall_i || flush_i) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (cnt_q == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Divider interface, stall and writeback decoded from state and inputs
    always_comb begin
        div_start_o   = 1'b0;
        div_annul_o   = 1'b0;
        signed_div_o  = sgn_q;
        div_opdata1_o = op1_q;
        div_opdata2_o = op2_q;
        stallreq_o    = 1'b0;
        whilo_o       = 1'b0;
        hi_o          = '0;
        lo_o          = '0;
        div_zero_o    = 1'b0;
        case (state)
            IDLE: begin
                // Operands pass straight through so the divider sees them in
                // the same cycle start rises
                signed_div_o  = div_signed_i;
                div_opdata1_o = opdata1_i;
                div_opdata2_o = opdata2_i;
                if (req_ok) begin
                    if (cache_hit) begin
                        whilo_o    = 1'b1;
                        hi_o       = hit_hi;
                        lo_o       = hit_lo;
                        div_zero_o = hit_zero;
                    end else begin
                        div_start_o = 1'b1;
                        stallreq_o  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (flush_i) begin
                    div_annul_o = 1'b1;
                end else if (div_ready_i) begin
                    // start drops here so the divider returns to Free and a
                    // request in the next cycle starts cleanly
                    whilo_o    = 1'b1;
                    hi_o       = div_result_i[63:32];
                    lo_o       = div_result_i[31:0];
                    div_zero_o = (op2_q == '0);
                end else begin
                    div_start_o = 1'b1;
                    stallreq_o  = 1'b1;
                end
            end
            DRAIN: begin
                stallreq_o = req_ok;
            end
            default: ;
        endcase
        // Everything is held at zero while reset is asserted
        if (!rst) begin
            div_start_o   = 1'b0;
            div_annul_o   = 1'b0;
            signed_div_o  = 1'b0;
            div_opdata1_o = '0;
            div_opdata2_o = '0;
            stallreq_o    = 1'b0;
            whilo_o       = 1'b0;
            hi_o          = '0;
            lo_o          = '0;
            div_zero_o    = 1'b0;
        end
    end

endmodule
